decode_stage: RTL and testbench

- Registered, parametrised instruction-decode pipeline stage. Successor to the combinational DECODER for the pipelined core.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and decodes fields and control signals into an output pipeline register.
- Detects load-use hazards against recently issued loads and holds the dependent instruction for a configurable number of cycles.
- Supports flush and counts hazard stalls.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_logic.sv | 73 +++++++
 rtl/decode_stage.sv | 174 +++++++++++++++++
 tb/tb_decode_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode values, instruction field positions and the
// control bundle produced by decode_logic.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned JADDR_LSB = 0;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JADDR_W = 26;

  typedef struct packed {
    logic reg_we;
    logic mem_rd;
    logic mem_wr;
    logic branch;
    logic jump;
    logic illegal;
    logic uses_rs;
    logic uses_rt;
  } dec_ctrl_t;

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction decoder: splits the word into fields, selects the
// destination register, extends the immediate and derives the control bundle.
module decode_logic
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]         instr,
  output logic [OPC_W-1:0]    opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [XLEN-1:0]     imm,
  output logic [JADDR_W-1:0]  jaddr,
  output dec_ctrl_t           ctrl
);

  logic [IMM_W-1:0] imm16;

  assign opcode = instr[OPC_LSB +: OPC_W];
  assign rs     = instr[RS_LSB +: REG_W];
  assign rt     = instr[RT_LSB +: REG_W];
  assign shamt  = instr[SHAMT_LSB +: REG_W];
  assign funct  = instr[FUNCT_LSB +: FUNCT_W];
  assign imm16  = instr[IMM_LSB +: IMM_W];
  assign jaddr  = instr[JADDR_LSB +: JADDR_W];

  always_comb begin
    if (opcode == OP_ORI) imm = XLEN'(imm16);
    else                  imm = XLEN'($signed(imm16));
  end

  always_comb begin
    ctrl = '0;
    rd   = '0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_we  = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
        rd           = instr[RD_LSB +: REG_W];
      end
      OP_J: ctrl.jump = 1'b1;
      OP_BEQ, OP_BNE: begin
        ctrl.branch  = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_ADDI, OP_ORI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.uses_rs = 1'b1;
        rd           = rt;
      end
      OP_LW: begin
        ctrl.reg_we  = 1'b1;
        ctrl.mem_rd  = 1'b1;
        ctrl.uses_rs = 1'b1;
        rd           = rt;
      end
      OP_SW: begin
        ctrl.mem_wr  = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Writes to r0 are architecturally discarded, so never advertise them.
    if (rd == '0) ctrl.reg_we = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake into a single held slot,
// load-use hazard hold against recently issued loads, and a stall counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_funct,
  output logic [XLEN-1:0]  out_imm,
  output logic [25:0]      out_jaddr,
  output logic             out_reg_we,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned LDC_W = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;
  localparam logic [LDC_W-1:0] LDC_INIT = LDC_W'(LOAD_USE_STALL);

  logic [OPC_W-1:0]   dec_opcode;
  logic [REG_W-1:0]   dec_rs, dec_rt, dec_rd, dec_shamt;
  logic [FUNCT_W-1:0] dec_funct;
  logic [XLEN-1:0]    dec_imm;
  logic [JADDR_W-1:0] dec_jaddr;
  dec_ctrl_t          dec_ctrl;

  logic               held_valid_q, held_valid_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [REG_W-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [JADDR_W-1:0] jaddr_q, jaddr_d;
  dec_ctrl_t          ctrl_q, ctrl_d;
  logic [LDC_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [REG_W-1:0]   ld_dst_q, ld_dst_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic hazard, out_fire, in_fire;

  decode_logic #(.XLEN(XLEN)) u_decode_logic (
    .instr  (in_instr),
    .opcode (dec_opcode),
    .rs     (dec_rs),
    .rt     (dec_rt),
    .rd     (dec_rd),
    .shamt  (dec_shamt),
    .funct  (dec_funct),
    .imm    (dec_imm),
    .jaddr  (dec_jaddr),
    .ctrl   (dec_ctrl)
  );

  always_comb begin
    hazard = (ld_cnt_q != '0) && (ld_dst_q != '0) && held_valid_q &&
             ((ctrl_q.uses_rs && (rs_q == ld_dst_q)) ||
              (ctrl_q.uses_rt && (rt_q == ld_dst_q)));
    out_valid = held_valid_q && !hazard;
    out_fire  = out_valid && out_ready;
    in_ready  = !flush && (!held_valid_q || out_fire);
    in_fire   = in_valid && in_ready;
  end

  always_comb begin
    held_valid_d = held_valid_q;
    opcode_d     = opcode_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    shamt_d      = shamt_q;
    funct_d      = funct_q;
    imm_d        = imm_q;
    jaddr_d      = jaddr_q;
    ctrl_d       = ctrl_q;
    ld_cnt_d     = ld_cnt_q;
    ld_dst_d     = ld_dst_q;
    stall_cnt_d  = stall_cnt_q;

    if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (flush) begin
      held_valid_d = 1'b0;
      ld_cnt_d     = '0;
    end else begin
      if (out_fire && ctrl_q.mem_rd && (rd_q != '0)) begin
        ld_cnt_d = LDC_INIT;
        ld_dst_d = rd_q;
      end else if (ld_cnt_q != '0) begin
        ld_cnt_d = ld_cnt_q - LDC_W'(1);
      end

      if (in_fire) begin
        held_valid_d = 1'b1;
        opcode_d     = dec_opcode;
        rs_d         = dec_rs;
        rt_d         = dec_rt;
        rd_d         = dec_rd;
        shamt_d      = dec_shamt;
        funct_d      = dec_funct;
        imm_d        = dec_imm;
        jaddr_d      = dec_jaddr;
        ctrl_d       = dec_ctrl;
      end else if (out_fire) begin
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid_q <= 1'b0;
      opcode_q     <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      funct_q      <= '0;
      imm_q        <= '0;
      jaddr_q      <= '0;
      ctrl_q       <= '0;
      ld_cnt_q     <= '0;
      ld_dst_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      opcode_q     <= opcode_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      shamt_q      <= shamt_d;
      funct_q      <= funct_d;
      imm_q        <= imm_d;
      jaddr_q      <= jaddr_d;
      ctrl_q       <= ctrl_d;
      ld_cnt_q     <= ld_cnt_d;
      ld_dst_q     <= ld_dst_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_opcode  = opcode_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_rd      = rd_q;
  assign out_shamt   = shamt_q;
  assign out_funct   = funct_q;
  assign out_imm     = imm_q;
  assign out_jaddr   = jaddr_q;
  assign out_reg_we  = ctrl_q.reg_we;
  assign out_mem_rd  = ctrl_q.mem_rd;
  assign out_mem_wr  = ctrl_q.mem_wr;
  assign out_branch  = ctrl_q.branch;
  assign out_jump    = ctrl_q.jump;
  assign out_illegal = ctrl_q.illegal;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Two decode_stage instances (LOAD_USE_STALL=1 and =3 with a narrow counter)
// share one stimulus stream and are compared every cycle to a reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_instr;

  logic        in_ready [2];
  logic        out_valid [2];
  logic [5:0]  o_opcode [2];
  logic [4:0]  o_rs [2], o_rt [2], o_rd [2], o_shamt [2];
  logic [5:0]  o_funct [2];
  logic [31:0] o_imm [2];
  logic [25:0] o_jaddr [2];
  logic        o_reg_we [2], o_mem_rd [2], o_mem_wr [2];
  logic        o_branch [2], o_jump [2], o_illegal [2];
  logic [15:0] stall0;
  logic [3:0]  stall1;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .LOAD_USE_STALL(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_opcode(o_opcode[0]), .out_rs(o_rs[0]), .out_rt(o_rt[0]), .out_rd(o_rd[0]),
    .out_shamt(o_shamt[0]), .out_funct(o_funct[0]), .out_imm(o_imm[0]),
    .out_jaddr(o_jaddr[0]), .out_reg_we(o_reg_we[0]), .out_mem_rd(o_mem_rd[0]),
    .out_mem_wr(o_mem_wr[0]), .out_branch(o_branch[0]), .out_jump(o_jump[0]),
    .out_illegal(o_illegal[0]), .stall_cnt(stall0)
  );

  decode_stage #(.XLEN(32), .LOAD_USE_STALL(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_opcode(o_opcode[1]), .out_rs(o_rs[1]), .out_rt(o_rt[1]), .out_rd(o_rd[1]),
    .out_shamt(o_shamt[1]), .out_funct(o_funct[1]), .out_imm(o_imm[1]),
    .out_jaddr(o_jaddr[1]), .out_reg_we(o_reg_we[1]), .out_mem_rd(o_mem_rd[1]),
    .out_mem_wr(o_mem_wr[1]), .out_branch(o_branch[1]), .out_jump(o_jump[1]),
    .out_illegal(o_illegal[1]), .stall_cnt(stall1)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned opc, rs, rt, rd, sh, fn, ja;
    logic [31:0] imm;
    bit we, mr, mw, br, jp, il, urs, urt;
  } exp_t;

  // Reference decode written straight from the opcode table.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    int unsigned imm16;
    e = '{default: 0};
    e.opc = w / (1 << 26);
    e.rs  = (w / (1 << 21)) % 32;
    e.rt  = (w / (1 << 16)) % 32;
    e.sh  = (w / (1 << 6)) % 32;
    e.fn  = w % 64;
    e.ja  = w % (1 << 26);
    imm16 = w % 65536;
    e.imm = (e.opc != 13 && imm16 >= 32768) ? imm16 + 32'hFFFF0000 : imm16;
    case (e.opc)
      0:      begin e.we = 1; e.urs = 1; e.urt = 1; e.rd = (w / (1 << 11)) % 32; end
      2:      e.jp = 1;
      4, 5:   begin e.br = 1; e.urs = 1; e.urt = 1; end
      8, 13:  begin e.we = 1; e.urs = 1; e.rd = e.rt; end
      35:     begin e.we = 1; e.mr = 1; e.urs = 1; e.rd = e.rt; end
      43:     begin e.mw = 1; e.urs = 1; e.urt = 1; end
      default: e.il = 1;
    endcase
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  int unsigned lus [2]     = '{1, 3};
  int unsigned stl_max [2] = '{65535, 15};
  bit          m_hv [2];
  logic [31:0] m_instr [2];
  int unsigned m_ldc [2], m_ldd [2], m_stall [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hv[i] = 0; m_instr[i] = '0; m_ldc[i] = 0; m_ldd[i] = 0; m_stall[i] = 0;
    end
  endtask

  // One cycle: drive at negedge, compare just after, advance the model, wait for posedge.
  task automatic tick(input bit v, input logic [31:0] w, input bit fl, input bit ordy, input bit rst);
    exp_t e;
    bit hz, ov, ir;
    logic [63:0] got_stall;
    @(negedge clk);
    in_valid = v; in_instr = w; flush = fl; out_ready = ordy; rst_n = !rst;
    #1;
    for (int i = 0; i < 2; i++) begin
      e  = ref_dec(m_instr[i]);
      hz = (m_ldc[i] != 0) && m_hv[i] &&
           ((e.urs && e.rs == m_ldd[i]) || (e.urt && e.rt == m_ldd[i]));
      ov = m_hv[i] && !hz;
      ir = !fl && (!m_hv[i] || (ov && ordy));
      got_stall = (i == 0) ? 64'(stall0) : 64'(stall1);
      check_eq($sformatf("u%0d.out_valid", i), 64'(out_valid[i]), 64'(ov));
      check_eq($sformatf("u%0d.in_ready", i),  64'(in_ready[i]),  64'(ir));
      check_eq($sformatf("u%0d.stall_cnt", i), got_stall,         64'(m_stall[i]));
      check_eq($sformatf("u%0d.opcode", i),  64'(o_opcode[i]),  64'(e.opc));
      check_eq($sformatf("u%0d.rs", i),      64'(o_rs[i]),      64'(e.rs));
      check_eq($sformatf("u%0d.rt", i),      64'(o_rt[i]),      64'(e.rt));
      check_eq($sformatf("u%0d.rd", i),      64'(o_rd[i]),      64'(e.rd));
      check_eq($sformatf("u%0d.shamt", i),   64'(o_shamt[i]),   64'(e.sh));
      check_eq($sformatf("u%0d.funct", i),   64'(o_funct[i]),   64'(e.fn));
      check_eq($sformatf("u%0d.imm", i),     64'(o_imm[i]),     64'(e.imm));
      check_eq($sformatf("u%0d.jaddr", i),   64'(o_jaddr[i]),   64'(e.ja));
      check_eq($sformatf("u%0d.ctrl", i),
               64'({o_reg_we[i], o_mem_rd[i], o_mem_wr[i], o_branch[i], o_jump[i], o_illegal[i]}),
               64'({e.we, e.mr, e.mw, e.br, e.jp, e.il}));

      if (rst) begin
        m_hv[i] = 0; m_instr[i] = '0; m_ldc[i] = 0; m_ldd[i] = 0; m_stall[i] = 0;
      end else begin
        if (hz && m_stall[i] < stl_max[i]) m_stall[i]++;
        if (fl) begin
          m_hv[i]  = 0;
          m_ldc[i] = 0;
        end else begin
          if (ov && ordy && e.mr && e.rd != 0) begin
            m_ldc[i] = lus[i];
            m_ldd[i] = e.rd;
          end else if (m_ldc[i] > 0) begin
            m_ldc[i]--;
          end
          if (v && ir) begin
            m_instr[i] = w;
            m_hv[i]    = 1;
          end else if (ov && ordy) begin
            m_hv[i] = 0;
          end
        end
      end
    end
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned ops [10] = '{0, 2, 4, 5, 8, 13, 35, 35, 43, 63};
    w = $urandom;
    w[31:26] = 6'(ops[$urandom_range(0, 9)]);
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[15:11] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    tick(0, 32'h0, 0, 1, 1);
    tick(0, 32'h0, 0, 1, 0);

    // Basic decode and immediate extension.
    tick(1, 32'h00221820, 0, 1, 0);
    tick(1, 32'h2005FFFF, 0, 1, 0);
    tick(1, 32'h3405FFFF, 0, 1, 0);
    tick(0, 32'h0, 0, 1, 0);

    // Load followed by a dependent ADD, held until both instances take it.
    tick(1, 32'h8C220004, 0, 1, 0);
    for (int k = 0; k < 6; k++) tick(1, 32'h00421820, 0, 1, 0);
    repeat (4) tick(0, 32'h0, 0, 1, 0);

    // Back-pressure with a load held, then release at full rate.
    tick(1, 32'h8C220004, 0, 1, 0);
    repeat (4) tick(1, 32'h00221820, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick(1, 32'h2005FFFF + 32'(k), 0, 1, 0);
    repeat (4) tick(0, 32'h0, 0, 1, 0);

    // Flush while a load is held and a dependent ADD arrives.
    tick(1, 32'h8C220004, 0, 0, 0);
    tick(1, 32'h00421820, 1, 1, 0);
    repeat (3) tick(0, 32'h0, 0, 1, 0);

    // Illegal opcode passes through.
    tick(1, 32'hFC000000, 0, 1, 0);
    tick(0, 32'h0, 0, 1, 0);

    // Reset in the middle of a stall.
    tick(1, 32'h8C220004, 0, 1, 0);
    tick(1, 32'h00421820, 0, 1, 0);
    tick(0, 32'h0, 0, 1, 0);
    tick(0, 32'h0, 0, 1, 1);
    tick(0, 32'h0, 0, 1, 0);

    // Randomised traffic; saturates the narrow counter on the second instance.
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
